// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter family.
// TIMEOUT and CNT_W exist only when ARB_TIMEOUT_EN is defined.
package arb_pkg;

  localparam int N     = 10;
  localparam int IDX_W = 4;

  localparam logic [IDX_W-1:0] IDX_NONE = 4'b1111;

`ifdef ARB_TIMEOUT_EN
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = $clog2(TIMEOUT + 1);
`endif

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  // Binary encode of a one-hot vector; IDX_NONE when the vector is empty.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = (oh == '0) ? IDX_NONE : '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: the first set request at or after ptr,
// wrapping past N-1. Rotate, fixed-priority scan, then un-rotate.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [N-1:0] rot_req;
  logic [N-1:0] rot_gnt;

  // Rotating right by ptr puts requester ptr at bit 0.
  assign rot_req = N'({req, req} >> ptr);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    rot_gnt = '0;
    for (int i = 0; i < N; i++) begin
      if (rot_req[i] && (rot_gnt == '0)) rot_gnt[i] = 1'b1;
    end
  end

  // Shifting the doubled vector right by N-ptr is a left rotate by ptr.
  assign gnt   = N'({rot_gnt, rot_gnt} >> (IDX_W'(N) - ptr));
  assign idx   = onehot_to_idx(gnt);
  assign valid = |req;

endmodule

// File: rtl/rr_arbiter_sv.sv
// Round-robin arbiter for N requesters with hold-until-release grants.
// Optional hold timeout and oTIMEOUT output under macro ARB_TIMEOUT_EN.
module rr_arbiter_sv
  import arb_pkg::*;
(
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic [N-1:0]     iREQ,
  input  logic             iDONE,
  output logic [N-1:0]     oGNT,
  output logic [IDX_W-1:0] oGNT_IDX,
  output logic             oVALID
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             oTIMEOUT
`endif
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     gnt_q, gnt_d;

  logic [N-1:0]     pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             release_req;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  rr_pick u_pick (
    .req   (iREQ),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // The owner releases by pulsing iDONE or by dropping its own request.
  assign release_req = iDONE || !(|(iREQ & gnt_q));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          ptr_d   = (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (release_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = IDX_NONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = IDX_NONE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = IDX_NONE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= IDX_NONE;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign oGNT     = gnt_q;
  assign oGNT_IDX = idx_q;
  assign oVALID   = |gnt_q;
`ifdef ARB_TIMEOUT_EN
  assign oTIMEOUT = tmo_q;
`endif

endmodule

// File: tb/tb_rr_arbiter_sv.sv
// Randomized bench for rr_arbiter_sv against a behavioural owner/pointer model,
// plus directed scenarios pinned with hand-computed values.
module tb_rr_arbiter_sv;
  import arb_pkg::*;

  logic             iCLK  = 1'b0;
  logic             iRSTn = 1'b0;
  logic [N-1:0]     iREQ  = '0;
  logic             iDONE = 1'b0;
  logic [N-1:0]     oGNT;
  logic [IDX_W-1:0] oGNT_IDX;
  logic             oVALID;
`ifdef ARB_TIMEOUT_EN
  logic             oTIMEOUT;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Model: owner number (-1 = none), next scan start, cycles held, timeout flag.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_age   = 0;
  bit m_tmo   = 1'b0;

  always #5 iCLK = ~iCLK;

  rr_arbiter_sv dut (
    .iCLK     (iCLK),
    .iRSTn    (iRSTn),
    .iREQ     (iREQ),
    .iDONE    (iDONE),
    .oGNT     (oGNT),
    .oGNT_IDX (oGNT_IDX),
    .oVALID   (oVALID)
`ifdef ARB_TIMEOUT_EN
    ,
    .oTIMEOUT (oTIMEOUT)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_age   = 0;
    m_tmo   = 1'b0;
  endfunction

  // Advance the model by one clock edge given the inputs seen before the edge.
  function automatic void model_step(input logic [N-1:0] req, input logic done);
    int j;
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      for (int off = 0; off < N; off++) begin
        j = (m_ptr + off) % N;
        if (req[j]) begin
          m_owner = j;
          m_ptr   = (j + 1) % N;
          m_age   = 1;
          break;
        end
      end
    end else if (done || !req[m_owner]) begin
      m_owner = -1;
    end
`ifdef ARB_TIMEOUT_EN
    else if (m_age == TIMEOUT) begin
      m_owner = -1;
      m_tmo   = 1'b1;
    end
`endif
    else begin
      m_age++;
    end
  endfunction

  task automatic compare_outputs();
    logic [N-1:0]     exp_gnt;
    logic [IDX_W-1:0] exp_idx;
    exp_gnt = '0;
    exp_idx = 4'hF;
    if (m_owner >= 0) begin
      exp_gnt[m_owner] = 1'b1;
      exp_idx = IDX_W'(m_owner);
    end
    check("gnt", oGNT, exp_gnt);
    check("gnt_idx", oGNT_IDX, exp_idx);
    check("valid", oVALID, (m_owner >= 0));
    check("onehot0", $onehot0(oGNT), 1);
`ifdef ARB_TIMEOUT_EN
    check("timeout", oTIMEOUT, m_tmo);
`endif
  endtask

  task automatic cycle(input logic [N-1:0] req, input logic done);
    @(negedge iCLK);
    iREQ  = req;
    iDONE = done;
    model_step(req, done);
    @(posedge iCLK);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    iRSTn = 1'b0;
    iREQ  = '0;
    iDONE = 1'b0;
    model_reset();
    repeat (2) @(negedge iCLK);
    check("rst_gnt", oGNT, 0);
    check("rst_idx", oGNT_IDX, 4'hF);
    check("rst_valid", oVALID, 0);
    iRSTn = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    int held;

    // Single request: 1-cycle latency, pointer moves to 3.
    do_reset();
    cycle(10'h004, 1'b0);
    check("first_gnt", oGNT, 10'h004);
    check("first_idx", oGNT_IDX, 2);
    cycle(10'h004, 1'b1);
    check("first_release", oGNT_IDX, 4'hF);
    cycle(10'h3FF, 1'b0);
    check("ptr_after_2", oGNT_IDX, 3);
    cycle(10'h3FF, 1'b1);

    // All requesting, iDONE on every second grant cycle: 0..9,0 with dead cycles.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cycle(10'h3FF, 1'b0);
      check("rr_seq", oGNT_IDX, i % 10);
      cycle(10'h3FF, 1'b0);
      cycle(10'h3FF, 1'b1);
      check("rr_dead", oGNT_IDX, 4'hF);
    end

    // Owner 9 then wrap to 0, then back to 9.
    cycle(10'h200, 1'b0);
    check("wrap_own9", oGNT_IDX, 9);
    cycle(10'h201, 1'b1);
    cycle(10'h201, 1'b0);
    check("wrap_to0", oGNT_IDX, 0);
    cycle(10'h201, 1'b1);
    cycle(10'h201, 1'b0);
    check("wrap_to9", oGNT_IDX, 9);
    cycle(10'h201, 1'b1);

    // Grant to 3 is unaffected by other requesters; dropping iREQ[3] releases.
    cycle(10'h008, 1'b0);
    for (int i = 0; i < 8; i++) begin
      r = N'($urandom) | 10'h008;
      cycle(r, 1'b0);
      check("hold3", oGNT, 10'h008);
    end
    r = N'($urandom) & ~10'h008;
    cycle(r, 1'b0);
    check("drop3_valid", oVALID, 0);

    // Asynchronous reset mid-grant clears outputs before any clock edge.
    cycle(10'h020, 1'b0);
    check("own5", oGNT_IDX, 5);
    #1 iRSTn = 1'b0;
    #1;
    check("async_gnt", oGNT, 0);
    check("async_idx", oGNT_IDX, 4'hF);
    check("async_valid", oVALID, 0);
    model_reset();
    iREQ  = '0;
    iDONE = 1'b0;
    @(negedge iCLK);
    iRSTn = 1'b1;
    cycle(10'h3FF, 1'b0);
    check("post_rst_first", oGNT_IDX, 0);
    cycle(10'h3FF, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // Owner 7 holds without iDONE: forced release after exactly TIMEOUT cycles.
    do_reset();
    cycle(10'h080, 1'b0);
    held = oVALID ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      cycle(10'h3FF, 1'b0);
      if (!oVALID) break;
      held++;
    end
    check("tmo_len", held, 16);
    check("tmo_pulse", oTIMEOUT, 1);
    cycle(10'h3FF, 1'b0);
    check("tmo_next8", oGNT_IDX, 8);
    check("tmo_clear", oTIMEOUT, 0);
    cycle(10'h3FF, 1'b1);
`endif

    // Randomized traffic; the owner's request tends to persist.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
      cycle(r, ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
